instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage that owns the program counter, drives the byte address of the synchronous instruction ROM, and presents each fetched 32-bit word with its PC to decode through a valid/ready handshake. It sits directly upstream of the ROM. It sustains one instruction per cycle while decode accepts, holds the ROM address stable under backpressure, takes PC redirects from execute, and traps misaligned or out-of-range fetch addresses.

## Interface
- N, 32, instruction/PC width
- SIZE, 1024, ROM size in bytes; AW = log2(SIZE) from include/log2.vh
- RESET_PC, 0, PC loaded on reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous and active-high
- rom_addr  out  AW  byte address to ROM; ROM returns {mem[a+3..a]} one cycle later
- rom_data  in  N  ROM read word, registered inside ROM
- instr_valid  out  1  instr/instr_pc hold a fetched instruction
- instr_ready  in  1  decode accepts this cycle
- instr  out  N  = rom_data (pass-through); meaningful only while instr_valid
- instr_pc  out  N  PC of instr; faulting PC while fault
- redirect  in  1  load redirect_pc, discard current fetch
- redirect_pc  in  N  new PC
- fault  out  1  fetch address illegal; fetching stopped
- fetch_count  out  32  count of completed handshakes, wraps

## Operation
- PC legal iff pc[1:0]==0 and pc <= SIZE-4.
- States: ISSUE, VALID, FAULT. Registers: state, pc (N bits), fetch_count.
- next_pc (combinational), by priority:
  - redirect: redirect_pc
  - VALID && instr_ready: pc+4, N-bit add
  - otherwise: pc
- rom_addr = next_pc[AW-1:0], truncated.
- ISSUE: instr_valid=0. The ROM captures pc. At the next edge, go to VALID if pc is legal, else FAULT.
- VALID: instr_valid=1, instr_pc=pc.
  - Handshake (instr_ready=1): fetch_count+1; pc<=pc+4. Stay VALID if pc+4 is legal, else FAULT.
  - No ready: pc and rom_addr are unchanged, so the ROM re-reads the same word and instr stays stable.
- redirect (any state, including FAULT):
  - pc<=redirect_pc; next state is VALID if redirect_pc is legal, else FAULT.
  - A same-cycle handshake still counts; the redirect overrides pc+4.
- FAULT: instr_valid=0, fault=1, instr_pc=faulting PC. Stays in FAULT until a redirect.
- fetch_count wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values while rst=1: state=ISSUE, pc=RESET_PC, rom_addr=RESET_PC[AW-1:0], instr_valid=0, fault=0, instr_pc=RESET_PC, fetch_count=0.
- Deassertion: first edge after rst falls, ROM latches RESET_PC word and state becomes VALID. instr_valid=1 in the following cycle.
- Reset asserted mid-operation aborts immediately (async). Any pending instruction is dropped and is not counted.
- Latency redirect→instr_valid: 1 cycle. redirect at edge k is sampled; instr_valid=1 after edge k, with instr = word at redirect_pc.
- Throughput: 1 instruction/cycle with instr_ready held high, with no bubbles.
- instr_valid never drops without a handshake, redirect, or reset. instr and instr_pc are stable while valid && !ready.
- instr_ready is ignored outside VALID.
- fault and instr_valid are never both 1.

## Test plan
Setup: SIZE=1024, RESET_PC=0, ROM words 0x00000013@0, 0x00100093@4, 0x00200113@8, 0xDEADBEEF@1020.
- **Reset then stream:** rst 1→0, ready=1.
  - instr_valid rises 1 cycle after release.
  - instr/instr_pc sequence: 0x00000013/0, 0x00100093/4, 0x00200113/8 on consecutive cycles.
  - fetch_count=3 after those three handshakes.
- **Backpressure:** ready=0 for 5 cycles while valid at pc=4.
  - instr=0x00100093, instr_pc=4, rom_addr=4 held all 5 cycles; fetch_count unchanged.
  - Raising ready gives pc 8 next cycle.
- **Redirect:** redirect=1, redirect_pc=1020 with ready=1 at pc=4.
  - fetch_count+1.
  - Next cycle: instr=0xDEADBEEF, instr_pc=1020.
  - Handshake then → fault=1, instr_pc=1024, instr_valid=0.
- **Misaligned redirect:** redirect_pc=6.
  - Next cycle: fault=1, instr_pc=6, instr_valid=0.
  - Stays in FAULT with ready toggling.
  - redirect_pc=8 → instr=0x00200113 next cycle, fault=0.
- **Async reset mid-stream:** assert rst between edges while valid.
  - instr_valid=0, fetch_count=0, rom_addr=0 immediately, with no clock edge required.
- **Counter wrap:** force fetch_count=0xFFFFFFFF, complete one handshake → fetch_count=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, addresses the synchronous instruction ROM,
// and hands fetched words to decode over a valid/ready handshake.
module instr_fetch #(
   parameter int unsigned     N        = 32,
   parameter int unsigned     SIZE     = 1024,
   parameter logic [N-1:0]    RESET_PC = '0,
   localparam int unsigned    AW       = $clog2(SIZE)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] rom_addr,
   input  logic [N-1:0]  rom_data,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [N-1:0]  instr,
   output logic [N-1:0]  instr_pc,
   input  logic          redirect,
   input  logic [N-1:0]  redirect_pc,
   output logic          fault,
   output logic [31:0]   fetch_count
);

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      VALID = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [N-1:0] LAST_PC = N'(SIZE - 4);

   state_t         state, state_nxt;
   logic [N-1:0]   pc, next_pc;

   function automatic logic legal(input logic [N-1:0] p);
      return (p[1:0] == 2'b00) && (p <= LAST_PC);
   endfunction

   // The ROM is addressed with next_pc so the word lands exactly when pc takes that value;
   // holding next_pc==pc under backpressure keeps the ROM output stable.
   always_comb begin
      next_pc   = pc;
      state_nxt = state;
      if (redirect) begin
         next_pc   = redirect_pc;
         state_nxt = legal(redirect_pc) ? VALID : FAULT;
      end else begin
         case (state)
            ISSUE: state_nxt = legal(pc) ? VALID : FAULT;
            VALID: begin
               if (instr_ready) begin
                  next_pc   = pc + N'(4);
                  state_nxt = legal(next_pc) ? VALID : FAULT;
               end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = ISSUE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ISSUE;
         pc          <= RESET_PC;
         instr_valid <= 1'b0;
         fault       <= 1'b0;
         fetch_count <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= next_pc;
         instr_valid <= (state_nxt == VALID);
         fault       <= (state_nxt == FAULT);
         if (state == VALID && instr_ready)
            fetch_count <= fetch_count + 32'd1;
      end
   end

   assign rom_addr = next_pc[AW-1:0];
   assign instr    = rom_data;
   assign instr_pc = pc;

endmodule
